// File: rtl/moore_detector.sv
// Moore FSM detecting the overlapping serial pattern "0110"; y_out is decoded from state only.
// Optional saturating match counter is enabled by defining MOORE_MATCH_COUNT_EN.
module moore_detector #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x_in,
    output logic                 y_out
`ifdef MOORE_MATCH_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] match_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_0    = 3'b001,
        S_01   = 3'b010,
        S_011  = 3'b011,
        S_0110 = 3'b100
    } state_t;

    state_t current_state;
    state_t w_next_state;

    always_comb begin
        w_next_state = S_IDLE;
        case (current_state)
            S_IDLE:  w_next_state = x_in ? S_IDLE : S_0;
            S_0:     w_next_state = x_in ? S_01   : S_0;
            S_01:    w_next_state = x_in ? S_011  : S_0;
            S_011:   w_next_state = x_in ? S_IDLE : S_0110;
            // Trailing 0 of a match doubles as the first bit of the next one.
            S_0110:  w_next_state = x_in ? S_01   : S_0;
            default: w_next_state = S_IDLE;
        endcase
    end

`ifdef MOORE_MATCH_COUNT_EN
    logic [CNT_WIDTH-1:0] r_match_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= S_IDLE;
            r_match_count <= '0;
        end else begin
            current_state <= w_next_state;
            if ((w_next_state == S_0110) && (r_match_count != '1)) begin
                r_match_count <= r_match_count + CNT_WIDTH'(1);
            end
        end
    end

    assign match_count = r_match_count;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= S_IDLE;
        end else begin
            current_state <= w_next_state;
        end
    end
`endif

    assign y_out = (current_state == S_0110);

endmodule

// File: tb/tb_moore_detector.sv
// Directed, table-driven bench for moore_detector plus hand-written multi-cycle sequences.
module tb_moore_detector;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x_in = 1'b0;
    logic y_out;

    always #5 clk = ~clk;

`ifdef MOORE_MATCH_COUNT_EN
    logic [1:0] match_count;
    moore_detector #(.CNT_WIDTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .x_in        (x_in),
        .y_out       (y_out),
        .match_count (match_count)
    );
`else
    moore_detector dut (
        .clk   (clk),
        .reset (reset),
        .x_in  (x_in),
        .y_out (y_out)
    );
`endif

    typedef struct {
        logic       rst;
        logic       x;
        logic [2:0] exp_state;
        logic       exp_y;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic add(input logic rst, input logic x, input logic [2:0] st, input logic y);
        vec_t v;
        v.rst = rst;
        v.x = x;
        v.exp_state = st;
        v.exp_y = y;
        tbl.push_back(v);
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic x);
        @(negedge clk);
        reset = rst;
        x_in = x;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // Reset held for two edges
        add(1, 0, 3'b000, 0);
        add(1, 0, 3'b000, 0);
        // Simple match, then drop
        add(0, 0, 3'b001, 0);
        add(0, 1, 3'b010, 0);
        add(0, 1, 3'b011, 0);
        add(0, 0, 3'b100, 1);
        add(0, 0, 3'b001, 0);
        // No match from idle
        add(1, 0, 3'b000, 0);
        add(0, 1, 3'b000, 0);
        add(0, 1, 3'b000, 0);
        add(0, 1, 3'b000, 0);
        add(0, 1, 3'b000, 0);
        // Overlap 0110110
        add(0, 0, 3'b001, 0);
        add(0, 1, 3'b010, 0);
        add(0, 1, 3'b011, 0);
        add(0, 0, 3'b100, 1);
        add(0, 1, 3'b010, 0);
        add(0, 1, 3'b011, 0);
        add(0, 0, 3'b100, 1);
        // Near misses 01011100110
        add(1, 0, 3'b000, 0);
        add(0, 0, 3'b001, 0);
        add(0, 1, 3'b010, 0);
        add(0, 0, 3'b001, 0);
        add(0, 1, 3'b010, 0);
        add(0, 1, 3'b011, 0);
        add(0, 1, 3'b000, 0);
        add(0, 0, 3'b001, 0);
        add(0, 0, 3'b001, 0);
        add(0, 1, 3'b010, 0);
        add(0, 1, 3'b011, 0);
        add(0, 0, 3'b100, 1);
        // Mid-sequence reset discards the partial match
        add(1, 0, 3'b000, 0);
        add(0, 0, 3'b001, 0);
        add(0, 1, 3'b010, 0);
        add(0, 1, 3'b011, 0);
        add(1, 0, 3'b000, 0);
        add(0, 0, 3'b001, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].x);
            chk($sformatf("vec%0d_state", i), int'(dut.current_state), int'(tbl[i].exp_state));
            chk($sformatf("vec%0d_y", i), int'(y_out), int'(tbl[i].exp_y));
        end

        // Back-to-back pulses: positions and gap, never high twice in a row
        begin
            logic [6:0] bits;
            int first_pulse;
            int second_pulse;
            int n_pulses;
            int n_double;
            logic prev_y;
            bits = 7'b0110110;
            first_pulse = -1;
            second_pulse = -1;
            n_pulses = 0;
            n_double = 0;
            prev_y = 1'b0;
            step(1, 0);
            for (int i = 0; i < 7; i++) begin
                step(0, bits[6-i]);
                if (y_out) begin
                    n_pulses++;
                    if (first_pulse < 0) first_pulse = i + 1;
                    else second_pulse = i + 1;
                end
                if (y_out && prev_y) n_double++;
                prev_y = y_out;
            end
            chk("b2b_pulses", n_pulses, 2);
            chk("b2b_first", first_pulse, 4);
            chk("b2b_gap", second_pulse - first_pulse, 3);
            chk("b2b_double_high", n_double, 0);
        end

        // Bounded wait: y_out must rise on the edge that samples the final 0
        begin
            int waited;
            step(1, 0);
            step(0, 0);
            step(0, 1);
            step(0, 1);
            waited = 0;
            while (waited < 4) begin
                step(0, 0);
                waited++;
                if (y_out) break;
            end
            chk("latency_edges", waited, 1);
            step(0, 1);
            chk("latency_drop", int'(y_out), 0);
        end

`ifdef MOORE_MATCH_COUNT_EN
        // Four separate matches saturate a 2-bit counter at 3
        begin
            int exp_cnt;
            step(1, 0);
            chk("cnt_reset", int'(match_count), 0);
            exp_cnt = 0;
            for (int m = 0; m < 4; m++) begin
                step(0, 0);
                step(0, 1);
                step(0, 1);
                step(0, 0);
                if (exp_cnt < 3) exp_cnt++;
                chk($sformatf("cnt_match%0d", m), int'(match_count), exp_cnt);
                chk($sformatf("cnt_y%0d", m), int'(y_out), 1);
            end
            step(1, 0);
            chk("cnt_clear", int'(match_count), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
